// File: rtl/dino_motion.sv
// -----------------------------------------------------------------------------
// dino_motion
//
// Vertical-motion engine for the dino sprite. Position and velocity advance
// once per enabled physics step. On top of a plain gravity jump it provides:
// reduced gravity while the jump key is held during the rise, fast-fall while
// ducking in the air, a terminal-velocity clamp, a ceiling clamp, a one-cycle
// landing pulse, a game-over freeze and a cheat float that releases into a
// normal fall.
//
// Ports
//   myclk     in   physics clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   step      in   physics-step enable
//   key_jump  in   jump key (level)
//   key_duck  in   duck key (level)
//   over      in   game over, forces DEAD until rst
//   cheat     in   float request
//   pos       out  current top row (POS_W bits, down is larger)
//   vel       out  signed velocity, down positive
//   state     out  0 GROUND, 1 RISE, 2 FALL, 3 DEAD, 4 FLOAT
//   jumping   out  state is RISE or FALL
//   ducking   out  on the ground with duck held, no jump, not game over
//   landed    out  one-cycle pulse on touchdown
//   jump_cnt  out  jumps started, saturating at 255
// -----------------------------------------------------------------------------
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   GROUND  | resting at GROUND row, waiting for a jump on a step
//   RISE    | airborne, velocity negative (moving up)
//   FALL    | airborne, velocity zero or positive (moving down)
//   DEAD    | game over, everything frozen until rst
//   FLOAT   | cheat hover at CHEAT_POS; release drops into FALL
//
module dino_motion #(
    parameter int POS_W     = 9,
    parameter int V_W       = 5,
    parameter int GROUND    = 300,
    parameter int CEIL      = 0,
    parameter int INIT_V    = -15,
    parameter int G         = 1,
    parameter int G_HOLD    = 1,
    parameter int G_FAST    = 3,
    parameter int MAX_V     = 15,
    parameter int CHEAT_POS = 100
) (
    input  logic                  myclk,
    input  logic                  rst,
    input  logic                  step,
    input  logic                  key_jump,
    input  logic                  key_duck,
    input  logic                  over,
    input  logic                  cheat,
    output logic [POS_W-1:0]      pos,
    output logic signed [V_W-1:0] vel,
    output logic [2:0]            state,
    output logic                  jumping,
    output logic                  ducking,
    output logic                  landed,
    output logic [7:0]            jump_cnt
);

    // Position arithmetic carries two extra bits so that overshoot past the
    // ground and undershoot past the ceiling are both visible as signed values.
    localparam int PW = POS_W + 2;
    // Velocity arithmetic carries one extra bit so vel + g cannot wrap before
    // the terminal-velocity clamp sees it.
    localparam int VW = V_W + 1;

    localparam logic signed [PW-1:0]  GROUND_W  = PW'(GROUND);
    localparam logic signed [PW-1:0]  CEIL_W    = PW'(CEIL);
    localparam logic signed [VW-1:0]  MAX_V_W   = VW'(MAX_V);
    localparam logic signed [VW-1:0]  G_W       = VW'(G);
    localparam logic signed [VW-1:0]  G_HOLD_W  = VW'(G_HOLD);
    localparam logic signed [VW-1:0]  G_FAST_W  = VW'(G_FAST);
    localparam logic [POS_W-1:0]      GROUND_P  = POS_W'(GROUND);
    localparam logic [POS_W-1:0]      CEIL_P    = POS_W'(CEIL);
    localparam logic [POS_W-1:0]      CHEAT_P   = POS_W'(CHEAT_POS);
    localparam logic signed [V_W-1:0] INIT_V_V  = V_W'(INIT_V);
    localparam logic signed [V_W-1:0] MAX_V_V   = V_W'(MAX_V);

    typedef enum logic [2:0] {
        S_GROUND = 3'd0,
        S_RISE   = 3'd1,
        S_FALL   = 3'd2,
        S_DEAD   = 3'd3,
        S_FLOAT  = 3'd4
    } st_t;

    st_t st;

    logic signed [VW-1:0]  g_sel;
    logic signed [VW-1:0]  nv_sum;
    logic signed [V_W-1:0] nv;
    logic signed [PW-1:0]  np;

    // Duck overrides everything; the hold bonus only applies on the way up.
    always_comb begin
        g_sel = G_W;
        if (key_duck) begin
            g_sel = G_FAST_W;
        end else if ((st == S_RISE) && key_jump) begin
            g_sel = G_HOLD_W;
        end
    end

    assign np     = $signed({2'b00, pos}) + PW'(vel);
    assign nv_sum = VW'(vel) + g_sel;
    assign nv     = (nv_sum > MAX_V_W) ? MAX_V_V : nv_sum[V_W-1:0];

    always_ff @(posedge myclk) begin
        if (rst) begin
            st       <= S_GROUND;
            pos      <= GROUND_P;
            vel      <= '0;
            landed   <= 1'b0;
            jump_cnt <= '0;
        end else begin
            landed <= 1'b0;
            if (over) begin
                st  <= S_DEAD;
                vel <= '0;
            end else if (st == S_DEAD) begin
                st <= S_DEAD;
            end else if (cheat) begin
                st  <= S_FLOAT;
                pos <= CHEAT_P;
                vel <= '0;
            end else if (st == S_FLOAT) begin
                // Release drops from rest; pos stays at the float row.
                st  <= S_FALL;
                vel <= '0;
            end else if (step) begin
                case (st)
                    S_GROUND: begin
                        if (key_jump) begin
                            st  <= S_RISE;
                            vel <= INIT_V_V;
                            if (jump_cnt != 8'hFF) begin
                                jump_cnt <= jump_cnt + 8'd1;
                            end
                        end
                    end
                    S_RISE, S_FALL: begin
                        if (np >= GROUND_W) begin
                            st     <= S_GROUND;
                            pos    <= GROUND_P;
                            vel    <= '0;
                            landed <= 1'b1;
                        end else if (np < CEIL_W) begin
                            st  <= S_FALL;
                            pos <= CEIL_P;
                            vel <= '0;
                        end else begin
                            pos <= np[POS_W-1:0];
                            vel <= nv;
                            if ((st == S_RISE) && !nv[V_W-1]) begin
                                st <= S_FALL;
                            end
                        end
                    end
                    default: begin
                        st <= st;
                    end
                endcase
            end
        end
    end

    assign state   = st;
    assign jumping = (st == S_RISE) || (st == S_FALL);
    assign ducking = (st == S_GROUND) && key_duck && !key_jump && !over;

endmodule
